// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer sizing for the stream FIFO family.
package fifo_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 16;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port array, synchronous write and asynchronous read.
module fifo_mem #(
    parameter int DEPTH = fifo_pkg::DEF_DEPTH,
    parameter int WIDTH = fifo_pkg::DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stream.sv
// fifo_stream: first-word-fall-through valid/ready FIFO with occupancy count,
// almost flags, synchronous flush and a sticky overflow flag.
module fifo_stream
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE = PW'(AE_LEVEL);
    localparam logic [PW-1:0] WRAP = {1'b1, {AW{1'b0}}};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
        $error("fifo_stream: DEPTH must be a power of two >= 2 and levels in range");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr ^ rd_ptr) == WRAP;
    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign almost_full  = count >= AF;
    assign almost_empty = count <= AE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count    <= push && !pop ? count + PW'(1) : pop && !push ? count - PW'(1) : count;
            overflow <= overflow || (in_valid && !in_ready);
        end

    // A flushed push must not land in memory, or it would reappear after a later wrap.
    fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

    a_count_tracks_ptrs: assert property (@(posedge clk) disable iff (rst) count == wr_ptr - rd_ptr);
    a_count_bounded: assert property (@(posedge clk) disable iff (rst) count <= PW'(DEPTH));

endmodule

// File: tb/tb_fifo_stream.sv
// tb_fifo_stream: directed stimulus with a queue scoreboard checked by an
// independent monitor on the falling clock edge.
module tb_fifo_stream;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [3:0]       count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;

    int               n_cmp = 0;
    int               n_err = 0;
    int               mcount = 0;
    bit               movf = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    fifo_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("count", 32'(count), 32'(mcount));
        chk("in_ready", 32'(in_ready), 32'(mcount < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mcount > 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 1));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    // Check registered state, drive one cycle of inputs, advance the model, clock once.
    task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        bit acc;
        bit del;
        chk_state();
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = iv && mcount < DEPTH;
        del = ordy && mcount > 0;
        if (fl) begin
            exp_q.delete();
            mcount = 0;
            movf   = 1'b0;
        end else begin
            if (acc) exp_q.push_back(d);
            mcount = mcount + int'(acc) - int'(del);
            movf   = movf || (iv && !acc);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mcount > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drained_scoreboard", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk)
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got 0x%0h expected nothing at %0t", out_data, $time);
            end else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_state();

        // Fill and drain
        for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drain();
        chk_state();

        // Latency: nothing visible in the push cycle, head visible one cycle later
        chk("latency_before", 32'(out_valid), 32'd0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_data", 32'(out_data), 32'hBEEF);
        drain();

        // Streaming across several pointer wraps
        for (int i = 0; i < 40; i++) step(1'b1, WIDTH'(16'h0100 + i), 1'b1, 1'b0);
        chk("stream_count", 32'(count), 32'd1);
        drain();

        // Full edge: pop only, rejected word sets overflow and is never stored
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b0, 1'b0);
        step(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("full_edge_count", 32'(count), 32'd7);
        chk("full_edge_overflow", 32'(overflow), 32'd1);
        drain();

        // Flush overrides concurrent push and pop
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h0300 + i), 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_overflow", 32'(overflow), 32'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h1235, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h0400 + i), 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        mcount = 0;
        movf   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 16'h0501, 1'b0, 1'b0);
        step(1'b1, 16'h0502, 1'b1, 1'b0);
        drain();
        chk_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_stream.md
Name: fifo_stream

Overview:
Parametrised successor to the team's basic synchronous FIFO. It uses a valid/ready stream handshake on both sides with first-word-fall-through output. All DEPTH entries are usable, with no sacrificed slot. It adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and a sticky overflow error flag. It buffers between producer and consumer pipeline stages anywhere in the design.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2 (elaboration-time assertion).
- WIDTH, 16, data width in bits.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- in_valid  in  1  producer has data.
- in_data  in  WIDTH  write data.
- in_ready  out  1  FIFO can accept; equals !full.
- out_valid  out  1  out_data holds the head entry; equals !empty.
- out_data  out  WIDTH  head entry; combinational read of the memory at the read pointer.
- out_ready  in  1  consumer takes the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky; set by in_valid && !in_ready.

Behaviour:
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The low bits index memory; the MSB is a wrap bit.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- push = in_valid && in_ready. The memory is written at wr_ptr and wr_ptr increments.
- pop = out_valid && out_ready. rd_ptr increments.
- Latency: data pushed into an empty FIFO is visible on out_data with out_valid=1 in the next cycle. There is no same-cycle bypass.
- Full FIFO: in_ready=0 even if out_ready=1 that cycle; no push-through-on-pop. Pushing resumes the cycle after a pop.
- Simultaneous push and pop (neither full nor empty): both pointers advance and count is unchanged.
- count: registered.
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flags: almost_full and almost_empty are combinational compares of the registered count.
- out_data when out_valid=0: don't-care. The bench must not check it.
- overflow:
  - Set the cycle after any cycle with in_valid=1 and in_ready=0.
  - Cleared only by rst or flush.
  - The rejected data is not stored; the producer is expected to hold it.
- flush (synchronous):
  - Next cycle: wr_ptr=rd_ptr=0, count=0, overflow=0.
  - Overrides any push or pop in the same cycle; neither takes effect.
  - in_ready and out_valid still reflect the pre-flush state during the flush cycle.
- rst (asynchronous, any time including mid-transfer):
  - Immediately: pointers=0, count=0, overflow=0, so out_valid=0, in_ready=1, almost_empty=1, almost_full=(AF_LEVEL==0, never by range).
  - Memory contents are not cleared.
  - First push is accepted on the first rising edge after rst deasserts.
- No X propagation: all control registers are reset; the memory array is not.

Decomposition:
- Package fifo_pkg:
  - function ptr_width(depth) returning $clog2(depth)+1.
  - Localparams for the default DEPTH and WIDTH.
- Sub-module fifo_mem: simple dual-port array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset; infers distributed RAM.
- fifo_stream holds the pointers, count, flags and handshake logic.

Test Plan (DEPTH=8, WIDTH=16, AF_LEVEL=6, AE_LEVEL=1):
- Fill and drain: push 0x0001..0x0008 with out_ready=0. Required: count steps 1..8; in_ready=0 after the 8th push; almost_full from count=6. Then drain with out_ready=1. Required: out_data is 0x0001..0x0008 in order; out_valid=0 after the last pop; almost_empty at count<=1.
- Latency: push 0xBEEF into an empty FIFO at cycle N. Required: out_valid=1 and out_data=0xBEEF at cycle N+1, not at N.
- Streaming wrap: hold in_valid=out_ready=1 for 40 cycles with an incrementing data pattern. Required: count stays at 1 in steady state; output sequence equals input sequence across more than two pointer wraps.
- Full edge: at count=8 drive in_valid=1, in_data=0x00AA, out_ready=1. Required: pop only; count=7; overflow=1 next cycle; 0x00AA never appears on the output.
- Flush: at count=5 assert flush together with in_valid=1 and out_ready=1. Required next cycle: count=0, out_valid=0, overflow=0; subsequent push 0x1234 is read back first.
- Async reset: assert rst mid-cycle at count=4. Required: out_valid=0, count=0, in_ready=1 before the next clk edge; normal operation after release.
